// File: rtl/dcache_uncached_responder_if.sv
// Bundle of the MMU-facing dual-port request signals and the cache-to-AXI bridge
// signals seen by the uncached responder; slave is the responder's view.
interface dcache_uncached_responder_if #(
  parameter int TAG_WIDTH    = 20,
  parameter int INDEX_WIDTH  = 8,
  parameter int OFFSET_WIDTH = 4
);
  // MMU request side
  logic                    p0_valid;
  logic                    p1_valid;
  logic [2:0]              op;
  logic [TAG_WIDTH-1:0]    tag;
  logic [INDEX_WIDTH-1:0]  index;
  logic [OFFSET_WIDTH-1:0] p0_offset;
  logic [OFFSET_WIDTH-1:0] p1_offset;
  logic [3:0]              p0_wstrb;
  logic [3:0]              p1_wstrb;
  logic [31:0]             p0_wdata;
  logic [31:0]             p1_wdata;
  logic [1:0]              p0_size;
  logic [1:0]              p1_size;
  logic                    addr_ok;
  logic                    data_ok;
  logic [31:0]             p0_rdata;
  logic [31:0]             p1_rdata;

  // Bridge side
  logic                    rd_req;
  logic [2:0]              rd_type;
  logic [31:0]             rd_addr;
  logic                    rd_rdy;
  logic                    ret_valid;
  logic                    ret_last;
  logic [31:0]             ret_data;
  logic                    wr_req;
  logic [2:0]              wr_type;
  logic [31:0]             wr_addr;
  logic [3:0]              wr_wstrb;
  logic [31:0]             wr_data;
  logic                    wr_rdy;

  modport slave (
    input  p0_valid, p1_valid, op, tag, index, p0_offset, p1_offset,
           p0_wstrb, p1_wstrb, p0_wdata, p1_wdata, p0_size, p1_size,
    output addr_ok, data_ok, p0_rdata, p1_rdata,
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );

  modport master (
    output p0_valid, p1_valid, op, tag, index, p0_offset, p1_offset,
           p0_wstrb, p1_wstrb, p0_wdata, p1_wdata, p0_size, p1_size,
    input  addr_ok, data_ok, p0_rdata, p1_rdata,
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );
endinterface

// File: rtl/dcache_uncached_responder.sv
// Uncached dcache responder: serializes an accepted p0 (+ optional p1) request into
// single-word bridge transactions and returns one data_ok once all ports complete.
module dcache_uncached_responder #(
  parameter int TAG_WIDTH    = 20,
  parameter int INDEX_WIDTH  = 8,
  parameter int OFFSET_WIDTH = 4
) (
  input logic                        clk,
  input logic                        reset,
  dcache_uncached_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P0_REQ  = 3'd1,
    P0_WAIT = 3'd2,
    P1_REQ  = 3'd3,
    P1_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t      state, state_n;
  logic        is_wr, has_p1;
  logic [31:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1;
  logic [1:0]  size0, size1;
  logic [3:0]  wstrb0, wstrb1;
  logic        accept, in_req, on_p1, ret_beat, bus_done;
  logic        unused_op;

  assign accept    = (state == IDLE) && bus.p0_valid;
  assign in_req    = (state == P0_REQ) || (state == P1_REQ);
  assign on_p1     = (state == P1_REQ);
  assign ret_beat  = bus.ret_valid && bus.ret_last;
  assign bus_done  = is_wr ? bus.wr_rdy : bus.rd_rdy;
  assign unused_op = ^bus.op[2:1];

  assign bus.p0_rdata = rdata0;
  assign bus.p1_rdata = rdata1;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_n       = state;
    bus.addr_ok   = (state == IDLE) && !reset;
    bus.data_ok   = (state == RESP);
    bus.rd_req    = in_req && !is_wr;
    bus.wr_req    = in_req && is_wr;
    bus.rd_addr   = on_p1 ? addr1 : addr0;
    bus.rd_type   = {1'b0, on_p1 ? size1 : size0};
    bus.wr_addr   = on_p1 ? addr1 : addr0;
    bus.wr_type   = {1'b0, on_p1 ? size1 : size0};
    bus.wr_wstrb  = on_p1 ? wstrb1 : wstrb0;
    bus.wr_data   = on_p1 ? wdata1 : wdata0;
    case (state)
      IDLE:    if (bus.p0_valid) state_n = P0_REQ;
      // A write completes on its handshake; a read still waits for its last beat.
      P0_REQ:  if (bus_done) state_n = is_wr ? (has_p1 ? P1_REQ : RESP) : P0_WAIT;
      P0_WAIT: if (ret_beat) state_n = has_p1 ? P1_REQ : RESP;
      P1_REQ:  if (bus_done) state_n = is_wr ? RESP : P1_WAIT;
      P1_WAIT: if (ret_beat) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_wr  <= 1'b0;
      has_p1 <= 1'b0;
      addr0  <= '0;
      addr1  <= '0;
      size0  <= '0;
      size1  <= '0;
      wstrb0 <= '0;
      wstrb1 <= '0;
      wdata0 <= '0;
      wdata1 <= '0;
    end else if (accept) begin
      is_wr  <= bus.op[0];
      has_p1 <= bus.p1_valid;
      addr0  <= {bus.tag, bus.index, bus.p0_offset};
      addr1  <= {bus.tag, bus.index, bus.p1_offset};
      size0  <= bus.p0_size;
      size1  <= bus.p1_size;
      wstrb0 <= bus.p0_wstrb;
      wstrb1 <= bus.p1_wstrb;
      wdata0 <= bus.p0_wdata;
      wdata1 <= bus.p1_wdata;
    end
  end

  // Read results hold across writes and unused ports until the next capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (state == P0_WAIT && ret_beat) rdata0 <= bus.ret_data;
      if (state == P1_WAIT && ret_beat) rdata1 <= bus.ret_data;
    end
  end

endmodule

// File: tb/tb_dcache_uncached_responder.sv
// Scoreboard bench for dcache_uncached_responder: stimulus pushes expected bus
// beats and responses; a bridge model answers and a monitor pops and compares.
module tb_dcache_uncached_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dcache_uncached_responder_if bus ();

  dcache_uncached_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [2:0]  typ;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [31:0] p0;
    logic [31:0] p1;
  } resp_t;

  typedef enum {B_IDLE, B_RDY, B_RET} bphase_t;

  beat_t       bus_q[$];
  resp_t       resp_q[$];
  logic [31:0] ret_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          last_dok_cyc = 0;
  int          dok_count = 0;
  int          n_issued = 0;
  int          rdy_delay = 0;
  int          ret_delay = 0;
  bit          stray_en = 1'b0;
  logic [31:0] m_p0 = '0;
  logic [31:0] m_p1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bridge model: random or fixed ready/return delays, optional stray beats.
  bphase_t bphase = B_IDLE;
  int      b_cnt = 0;
  bit      b_rd = 1'b0;

  initial begin
    bus.rd_rdy = 0; bus.wr_rdy = 0; bus.ret_valid = 0; bus.ret_last = 0; bus.ret_data = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.rd_rdy = 0; bus.wr_rdy = 0; bus.ret_valid = 0; bus.ret_last = 0;
      bus.ret_data = $urandom;
      if (reset) begin
        bphase = B_IDLE;
        continue;
      end
      if (bphase == B_IDLE && (bus.rd_req || bus.wr_req)) begin
        b_rd   = bus.rd_req;
        b_cnt  = (rdy_delay < 0) ? int'($urandom_range(0, 3)) : rdy_delay;
        bphase = B_RDY;
      end
      if (bphase == B_RDY) begin
        if (b_cnt == 0) begin
          bus.rd_rdy = b_rd;
          bus.wr_rdy = !b_rd;
          if (b_rd) begin
            bphase = B_RET;
            b_cnt  = (ret_delay < 0) ? int'($urandom_range(0, 3)) : ret_delay;
          end else begin
            bphase = B_IDLE;
          end
        end else begin
          b_cnt--;
          if (stray_en) begin bus.ret_valid = 1; bus.ret_last = 1; end
        end
      end else if (bphase == B_RET) begin
        if (b_cnt == 0) begin
          bus.ret_valid = 1;
          bus.ret_last  = 1;
          bus.ret_data  = (ret_q.size() != 0) ? ret_q.pop_front() : 32'hBAD0BAD0;
          bphase = B_IDLE;
        end else begin
          b_cnt--;
          if (stray_en) begin bus.ret_valid = 1; bus.ret_last = 0; end
        end
      end
    end
  end

  // Monitor: compares every presented bus request and every data_ok.
  bit prev_dok = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_dok = 1'b0;
        continue;
      end
      if (bus.rd_req || bus.wr_req) begin
        check("rd_wr_exclusive", {31'b0, bus.rd_req & bus.wr_req}, 32'd0);
        if (bus_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_req: rd_req=%b wr_req=%b with nothing outstanding", bus.rd_req, bus.wr_req);
        end else begin
          beat_t e;
          e = bus_q[0];
          check("req_kind", {31'b0, bus.rd_req}, {31'b0, e.is_rd});
          check("req_addr", bus.rd_req ? bus.rd_addr : bus.wr_addr, e.addr);
          check("req_type", {29'b0, bus.rd_req ? bus.rd_type : bus.wr_type}, {29'b0, e.typ});
          if (bus.wr_req) begin
            check("wr_wstrb", {28'b0, bus.wr_wstrb}, {28'b0, e.strb});
            check("wr_data", bus.wr_data, e.data);
          end
          if ((bus.rd_req && bus.rd_rdy) || (bus.wr_req && bus.wr_rdy)) void'(bus_q.pop_front());
        end
      end
      if (bus.data_ok) begin
        check("addr_ok_in_resp", {31'b0, bus.addr_ok}, 32'd0);
        check("data_ok_single", {31'b0, prev_dok}, 32'd0);
        if (resp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_data_ok: p0_rdata=%h with nothing outstanding", bus.p0_rdata);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          check("p0_rdata", bus.p0_rdata, r.p0);
          check("p1_rdata", bus.p1_rdata, r.p1);
        end
        last_dok_cyc = cyc;
        dok_count++;
      end
      prev_dok = bus.data_ok;
    end
  end

  // Issues one request; expectations come from the read/write rules directly.
  task automatic issue(input bit wr, input bit two, input logic [19:0] t, input logic [7:0] idx,
                       input logic [3:0] o0, input logic [3:0] o1, input logic [1:0] s0,
                       input logic [1:0] s1, input logic [3:0] w0, input logic [3:0] w1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] r0, input logic [31:0] r1);
    int n = 0;
    while (!bus.addr_ok && n < 500) begin tick(); n++; end
    if (n >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL addr_ok_timeout: addr_ok=%b after %0d cycles, expected 1", bus.addr_ok, n);
      return;
    end
    bus.p0_valid = 1; bus.p1_valid = two; bus.op = {$urandom_range(0, 3), wr};
    bus.tag = t; bus.index = idx; bus.p0_offset = o0; bus.p1_offset = o1;
    bus.p0_size = s0; bus.p1_size = s1; bus.p0_wstrb = w0; bus.p1_wstrb = w1;
    bus.p0_wdata = d0; bus.p1_wdata = d1;
    bus_q.push_back('{!wr, {t, idx, o0}, {1'b0, s0}, w0, d0});
    if (two) bus_q.push_back('{!wr, {t, idx, o1}, {1'b0, s1}, w1, d1});
    if (!wr) begin
      m_p0 = r0;
      ret_q.push_back(r0);
      if (two) begin
        m_p1 = r1;
        ret_q.push_back(r1);
      end
    end
    resp_q.push_back('{m_p0, m_p1});
    n_issued++;
    acc_cyc = cyc;
    tick();
    bus.p0_valid = 0; bus.p1_valid = $urandom_range(0, 1); bus.op = 3'($urandom);
    bus.tag = 20'($urandom); bus.index = 8'($urandom); bus.p0_offset = 4'($urandom);
    bus.p1_offset = 4'($urandom); bus.p0_size = 2'($urandom); bus.p1_size = 2'($urandom);
    bus.p0_wstrb = 4'($urandom); bus.p1_wstrb = 4'($urandom);
    bus.p0_wdata = $urandom; bus.p1_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (resp_q.size() != 0 && n < 2000) begin tick(); n++; end
    if (n >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL completion_timeout: %0d responses outstanding, expected 0", resp_q.size());
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    bus.p0_valid = 0; bus.p1_valid = 0; bus.op = 0; bus.tag = 0; bus.index = 0;
    bus.p0_offset = 0; bus.p1_offset = 0; bus.p0_size = 0; bus.p1_size = 0;
    bus.p0_wstrb = 0; bus.p1_wstrb = 0; bus.p0_wdata = 0; bus.p1_wdata = 0;
    tick();
    tick();
    check("reset_addr_ok", {31'b0, bus.addr_ok}, 32'd0);
    check("reset_data_ok", {31'b0, bus.data_ok}, 32'd0);
    check("reset_rd_req", {31'b0, bus.rd_req}, 32'd0);
    check("reset_wr_req", {31'b0, bus.wr_req}, 32'd0);
    check("reset_rd_addr", bus.rd_addr, 32'd0);
    check("reset_p0_rdata", bus.p0_rdata, 32'd0);
    check("reset_p1_rdata", bus.p1_rdata, 32'd0);
    reset = 0;
    tick();
    check("post_reset_addr_ok", {31'b0, bus.addr_ok}, 32'd1);

    // Single read at minimum latency.
    rdy_delay = 0; ret_delay = 0; stray_en = 0;
    issue(0, 0, 20'h1FD00, 8'h00, 4'h4, 4'h0, 2'd2, 2'd0, 4'hF, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0);
    wait_idle();
    check("read_latency", 32'(last_dok_cyc - acc_cyc), 32'd3);

    // Dual read with delayed ready.
    rdy_delay = 2;
    issue(0, 1, 20'h1FD00, 8'h10, 4'h0, 4'h8, 2'd2, 2'd2, 4'hF, 4'hF, 32'h0, 32'h0, 32'h11111111, 32'h22222222);
    wait_idle();

    // Byte write under 3 cycles of backpressure; read data must not move.
    rdy_delay = 3;
    issue(1, 0, 20'h1FD00, 8'h20, 4'h3, 4'h0, 2'd0, 2'd0, 4'b1000, 4'h0, 32'hAB000000, 32'h0, 32'h0, 32'h0);
    wait_idle();
    check("write_latency", 32'(last_dok_cyc - acc_cyc), 32'd5);
    check("write_keeps_p0_rdata", bus.p0_rdata, 32'h11111111);

    // p1_valid alone is not a request.
    rdy_delay = 0;
    bus.p0_valid = 0; bus.p1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("p1_only_no_req", {30'b0, bus.rd_req, bus.wr_req}, 32'd0);
    end
    bus.p1_valid = 0;
    check("p1_only_addr_ok", {31'b0, bus.addr_ok}, 32'd1);

    // A request held while busy is not accepted.
    ret_delay = 6;
    issue(0, 0, 20'hABCDE, 8'h33, 4'h8, 4'h0, 2'd1, 2'd0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h5A5AA5A5, 32'h0);
    for (int i = 0; i < 3; i++) begin
      bus.p0_valid = 1; bus.tag = 20'($urandom);
      check("busy_addr_ok", {31'b0, bus.addr_ok}, 32'd0);
      tick();
    end
    bus.p0_valid = 0;
    wait_idle();

    // Stray beats in REQ and non-last beats in WAIT.
    stray_en = 1; rdy_delay = 2; ret_delay = 3;
    issue(0, 0, 20'h00F0F, 8'h44, 4'hC, 4'h0, 2'd2, 2'd0, 4'h0, 4'h0, 32'h0, 32'h0, 32'hC0FFEE00, 32'h0);
    issue(0, 1, 20'h00F0F, 8'h45, 4'h0, 4'h4, 2'd2, 2'd1, 4'h0, 4'h0, 32'h0, 32'h0, 32'h01234567, 32'h89ABCDEF);
    wait_idle();

    // Asynchronous reset while waiting for read data.
    stray_en = 0; rdy_delay = 0; ret_delay = 10;
    issue(0, 0, 20'h12345, 8'h66, 4'h4, 4'h0, 2'd2, 2'd0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h77777777, 32'h0);
    tick();
    #3;
    reset = 1;
    #1;
    check("midreset_rd_req", {31'b0, bus.rd_req}, 32'd0);
    check("midreset_data_ok", {31'b0, bus.data_ok}, 32'd0);
    check("midreset_addr_ok", {31'b0, bus.addr_ok}, 32'd0);
    bus_q.delete(); resp_q.delete(); ret_q.delete();
    m_p0 = '0; m_p1 = '0; n_issued = 0; dok_count = 0;
    tick();
    tick();
    check("midreset_p0_rdata", bus.p0_rdata, m_p0);
    reset = 0;
    tick();
    check("after_reset_addr_ok", {31'b0, bus.addr_ok}, 32'd1);
    ret_delay = 0;
    issue(0, 0, 20'h12345, 8'h67, 4'h0, 4'h0, 2'd2, 2'd0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h3C3C3C3C, 32'h0);
    wait_idle();
    check("after_reset_latency", 32'(last_dok_cyc - acc_cyc), 32'd3);

    // Randomized back-to-back traffic.
    rdy_delay = -1; ret_delay = -1;
    for (int i = 0; i < 40; i++) begin
      stray_en = 1'($urandom);
      issue(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom), 4'($urandom), 4'($urandom),
            2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 4'($urandom), 4'($urandom),
            $urandom, $urandom, $urandom, $urandom);
    end
    wait_idle();
    repeat (4) tick();
    check("final_bus_q_empty", 32'(bus_q.size()), 32'd0);
    check("final_data_ok_count", 32'(dok_count), 32'(n_issued));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
